// File: rtl/alt_vipitc130_is2vid_pkg.sv
// Shared constants for the IS2Vid mode-control slice: register map,
// status bit positions and the load-sequencer state encoding.
package alt_vipitc130_is2vid_pkg;

  // Avalon-MM register addresses
  localparam logic [1:0] ADDR_CTRL       = 2'd0;
  localparam logic [1:0] ADDR_STATUS     = 2'd1;
  localparam logic [1:0] ADDR_MODE_SEL   = 2'd2;
  localparam logic [1:0] ADDR_MODE_VALID = 2'd3;

  // Status register bit positions
  localparam int STAT_RUNNING = 0;
  localparam int STAT_PENDING = 1;
  localparam int STAT_INVALID = 2;

  // Mode-load sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_READ   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOAD   = 3'd4
  } mode_state_e;

endpackage

// File: rtl/alt_vipitc130_is2vid_mode_regs.sv
// Avalon-MM register file and readback mux for the IS2Vid mode control.
// Holds go, mode_select, mode_valid and the change_pending / invalid_mode
// flags; the sequencer in the parent sets and clears the flags.
module alt_vipitc130_is2vid_mode_regs #(
  parameter int NUMBER_OF_MODES = 4,
  parameter int MODE_W          = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 av_address,
  input  logic                       av_write,
  input  logic [31:0]                av_writedata,
  input  logic                       av_read,
  output logic [31:0]                av_readdata,
  input  logic                       running,
  input  logic                       seq_start,
  input  logic                       seq_discard,
  input  logic                       set_invalid,
  output logic                       go,
  output logic [MODE_W-1:0]          mode_select,
  output logic [NUMBER_OF_MODES-1:0] mode_valid,
  output logic                       change_pending
);
  import alt_vipitc130_is2vid_pkg::*;

  logic                       go_r;
  logic [MODE_W-1:0]          mode_select_r;
  logic [NUMBER_OF_MODES-1:0] mode_valid_r;
  logic                       pending_r;
  logic                       invalid_r;
  logic [31:0]                readdata_r;
  logic [31:0]                rd_mux_s;
  logic                       wr_ctrl_s;
  logic                       wr_status_s;
  logic                       wr_sel_s;
  logic                       wr_valid_s;
  logic                       pend_set_s;
  logic                       unused_wdata_s;

  assign wr_ctrl_s   = av_write && (av_address == ADDR_CTRL);
  assign wr_status_s = av_write && (av_address == ADDR_STATUS);
  assign wr_sel_s    = av_write && (av_address == ADDR_MODE_SEL);
  assign wr_valid_s  = av_write && (av_address == ADDR_MODE_VALID);
  // A new mode request, or starting from stopped, both need a load sequence
  assign pend_set_s  = wr_sel_s || (wr_ctrl_s && av_writedata[0] && !running);
  assign unused_wdata_s = ^av_writedata;

  // Writable configuration registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      go_r          <= 1'b0;
      mode_select_r <= '0;
      mode_valid_r  <= '0;
    end else begin
      if (wr_ctrl_s)  go_r          <= av_writedata[0];
      if (wr_sel_s)   mode_select_r <= av_writedata[MODE_W-1:0];
      if (wr_valid_s) mode_valid_r  <= av_writedata[NUMBER_OF_MODES-1:0];
    end
  end

  // change_pending: a new request wins over a same-cycle clear by the sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
    end else if (pend_set_s) begin
      pending_r <= 1'b1;
    end else if (seq_start || seq_discard) begin
      pending_r <= 1'b0;
    end
  end

  // invalid_mode: sticky, write-1-to-clear, a new detection wins over the clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      invalid_r <= 1'b0;
    end else if (set_invalid) begin
      invalid_r <= 1'b1;
    end else if (wr_status_s && av_writedata[STAT_INVALID]) begin
      invalid_r <= 1'b0;
    end
  end

  // Readback mux, zero-extended to the bus width
  always_comb begin
    rd_mux_s = 32'd0;
    case (av_address)
      ADDR_CTRL: rd_mux_s[0] = go_r;
      ADDR_STATUS: begin
        rd_mux_s[STAT_RUNNING] = running;
        rd_mux_s[STAT_PENDING] = pending_r;
        rd_mux_s[STAT_INVALID] = invalid_r;
      end
      ADDR_MODE_SEL:   rd_mux_s[MODE_W-1:0]          = mode_select_r;
      ADDR_MODE_VALID: rd_mux_s[NUMBER_OF_MODES-1:0] = mode_valid_r;
      default:         rd_mux_s = 32'd0;
    endcase
  end

  // Registered read data, one cycle after av_read, zero when not reading
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      readdata_r <= 32'd0;
    end else if (av_read) begin
      readdata_r <= rd_mux_s;
    end else begin
      readdata_r <= 32'd0;
    end
  end

  assign av_readdata    = readdata_r;
  assign go             = go_r;
  assign mode_select    = mode_select_r;
  assign mode_valid     = mode_valid_r;
  assign change_pending = pending_r;

endmodule

// File: rtl/alt_vipitc130_is2vid_mode_control.sv
// IS2Vid mode control: sequences a mode change (validate, read bank,
// let calculate_mode settle, strobe load) and only lets it land at a
// frame boundary, or immediately when the timing generator is stopped.
module alt_vipitc130_is2vid_mode_control #(
  parameter int NUMBER_OF_MODES = 4,
  parameter int MODE_W          = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        av_address,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic              av_read,
  output logic [31:0]       av_readdata,
  input  logic              frame_end,
  output logic [MODE_W-1:0] bank_addr,
  output logic              bank_rd,
  output logic              mode_load,
  output logic [MODE_W-1:0] active_mode,
  output logic              running
);
  import alt_vipitc130_is2vid_pkg::*;

  localparam int MODE_SPACE = 1 << MODE_W;

  mode_state_e                state_r;
  mode_state_e                state_next_s;
  logic [MODE_W-1:0]          seq_mode_r;
  logic [MODE_W-1:0]          bank_addr_r;
  logic                       bank_rd_r;
  logic                       mode_load_r;
  logic [MODE_W-1:0]          active_mode_r;
  logic                       running_r;
  logic                       go_s;
  logic [MODE_W-1:0]          mode_select_s;
  logic [NUMBER_OF_MODES-1:0] mode_valid_s;
  logic                       pending_s;
  logic [MODE_SPACE-1:0]      valid_ext_s;
  logic                       mode_ok_s;
  logic                       start_s;
  logic                       discard_s;
  logic                       set_invalid_s;

  alt_vipitc130_is2vid_mode_regs #(
    .NUMBER_OF_MODES (NUMBER_OF_MODES),
    .MODE_W          (MODE_W)
  ) u_regs (
    .clk            (clk),
    .rst_n          (rst_n),
    .av_address     (av_address),
    .av_write       (av_write),
    .av_writedata   (av_writedata),
    .av_read        (av_read),
    .av_readdata    (av_readdata),
    .running        (running_r),
    .seq_start      (start_s),
    .seq_discard    (discard_s),
    .set_invalid    (set_invalid_s),
    .go             (go_s),
    .mode_select    (mode_select_s),
    .mode_valid     (mode_valid_s),
    .change_pending (pending_s)
  );

  // Mode validity: indices beyond NUMBER_OF_MODES see a zero valid bit
  always_comb begin
    valid_ext_s = '0;
    valid_ext_s[NUMBER_OF_MODES-1:0] = mode_valid_s;
    mode_ok_s = valid_ext_s[seq_mode_r];
  end

  // Next-state logic and sequencer control strobes
  always_comb begin
    state_next_s  = state_r;
    start_s       = 1'b0;
    discard_s     = 1'b0;
    set_invalid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pending_s && go_s && (!running_r || frame_end)) begin
          state_next_s = ST_CHECK;
          start_s      = 1'b1;
        end else if (!go_s && running_r && frame_end) begin
          discard_s    = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (mode_ok_s) begin
          state_next_s  = ST_READ;
        end else begin
          state_next_s  = ST_IDLE;
          set_invalid_s = 1'b1;
        end
      end
      ST_READ:   state_next_s = ST_SETTLE;
      ST_SETTLE: state_next_s = ST_LOAD;
      ST_LOAD:   state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Latch the requested mode as the sequence leaves IDLE so later writes
  // cannot change the mode being loaded
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_mode_r <= '0;
    end else if (start_s) begin
      seq_mode_r <= mode_select_s;
    end
  end

  // Registered bank interface: strobe in READ, address held through LOAD
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_rd_r   <= 1'b0;
      bank_addr_r <= '0;
    end else begin
      bank_rd_r <= (state_next_s == ST_READ);
      if (state_next_s == ST_READ) bank_addr_r <= seq_mode_r;
    end
  end

  // Load strobe, active mode and run enable, all updated in the LOAD cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_load_r   <= 1'b0;
      active_mode_r <= '0;
      running_r     <= 1'b0;
    end else begin
      mode_load_r <= (state_next_s == ST_LOAD);
      if (state_next_s == ST_LOAD) begin
        active_mode_r <= seq_mode_r;
        running_r     <= 1'b1;
      end else if (discard_s) begin
        running_r     <= 1'b0;
      end
    end
  end

  assign bank_addr   = bank_addr_r;
  assign bank_rd     = bank_rd_r;
  assign mode_load   = mode_load_r;
  assign active_mode = active_mode_r;
  assign running     = running_r;

endmodule

// File: tb/tb_alt_vipitc130_is2vid_mode_control.sv
// Directed bench for the IS2Vid mode control. Expected load modes go into a
// scoreboard queue as each sequence is provoked; a monitor pops and compares
// on every mode_load.
module tb_alt_vipitc130_is2vid_mode_control;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_SEL    = 2'd2;
  localparam logic [1:0] A_VALID  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  av_address;
  logic        av_write;
  logic [31:0] av_writedata;
  logic        av_read;
  logic [31:0] av_readdata;
  logic        frame_end;
  logic [1:0]  bank_addr;
  logic        bank_rd;
  logic        mode_load;
  logic [1:0]  active_mode;
  logic        running;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic       prev_load = 1'b0;

  alt_vipitc130_is2vid_mode_control #(.NUMBER_OF_MODES(4), .MODE_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .av_address   (av_address),
    .av_write     (av_write),
    .av_writedata (av_writedata),
    .av_read      (av_read),
    .av_readdata  (av_readdata),
    .frame_end    (frame_end),
    .bank_addr    (bank_addr),
    .bank_rd      (bank_rd),
    .mode_load    (mode_load),
    .active_mode  (active_mode),
    .running      (running)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    av_address = a; av_writedata = d; av_write = 1'b1;
    step();
    av_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    av_address = a; av_read = 1'b1;
    step();
    av_read = 1'b0;
    chk(tag, av_readdata, exp);
  endtask

  // Called in the cycle whose edge starts the sequence; walks N+1..N+5
  task automatic seq_check(input logic [1:0] m, input bit mid_wr, input string tag);
    for (int i = 1; i <= 5; i++) begin
      step();
      frame_end = 1'b0;
      if (i == 4) av_write = 1'b0;
      chk($sformatf("%s_load_n%0d", tag, i), {31'd0, mode_load}, {31'd0, (i == 4)});
      chk($sformatf("%s_rd_n%0d", tag, i), {31'd0, bank_rd}, {31'd0, (i == 2)});
      if (i == 2) chk({tag, "_bank_addr"}, {30'd0, bank_addr}, {30'd0, m});
      if (i == 3 && mid_wr) begin
        av_address = A_SEL; av_writedata = 32'd0; av_write = 1'b1;
      end
    end
    chk({tag, "_active"}, {30'd0, active_mode}, {30'd0, m});
    chk({tag, "_running"}, {31'd0, running}, 32'd1);
  endtask

  // Scoreboard monitor: every mode_load must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mode_load === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0 && prev_load === 1'b0) else begin
        errors++;
        $error("FAIL load_unexpected observed=%0h expected=none", active_mode);
      end
      if (exp_q.size() > 0) begin
        logic [1:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (active_mode === e) else begin
          errors++;
          $error("FAIL load_mode observed=%0h expected=%0h", active_mode, e);
        end
      end
    end
    prev_load <= mode_load;
  end

  initial begin
    rst_n = 1'b0; av_address = 2'd0; av_write = 1'b0; av_writedata = 32'd0;
    av_read = 1'b0; frame_end = 1'b0;
    step(); step(); step();
    chk("rst_readdata", av_readdata, 32'd0);
    chk("rst_bank_addr", {30'd0, bank_addr}, 32'd0);
    chk("rst_bank_rd", {31'd0, bank_rd}, 32'd0);
    chk("rst_mode_load", {31'd0, mode_load}, 32'd0);
    chk("rst_active", {30'd0, active_mode}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    rst_n = 1'b1;
    step();
    rd(A_CTRL, 32'd0, "rst_ctrl_reg");
    rd(A_STATUS, 32'd0, "rst_status_reg");

    // Start from stopped: load lands 4 cycles after the go write, no frame_end
    wr(A_VALID, 32'h2);
    wr(A_SEL, 32'd1);
    rd(A_STATUS, 32'h2, "t1_pending");
    wr(A_CTRL, 32'd1);
    exp_q.push_back(2'd1);
    seq_check(2'd1, 1'b0, "t1");

    // Switch to mode 3 only at a frame boundary
    wr(A_VALID, 32'ha);
    wr(A_SEL, 32'd3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_no_early_load", {31'd0, mode_load}, 32'd0);
    end
    chk("t2_still_mode1", {30'd0, active_mode}, 32'd1);
    frame_end = 1'b1;
    exp_q.push_back(2'd3);
    seq_check(2'd3, 1'b0, "t2");

    // Invalid mode 2: no load, sticky flag, write-1-to-clear
    wr(A_SEL, 32'd2);
    step();
    frame_end = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      frame_end = 1'b0;
      chk("t3_no_load", {31'd0, mode_load}, 32'd0);
    end
    chk("t3_active_kept", {30'd0, active_mode}, 32'd3);
    rd(A_STATUS, 32'h5, "t3_status_invalid");
    wr(A_STATUS, 32'h4);
    rd(A_STATUS, 32'h1, "t3_status_cleared");

    // Mode_select write during SETTLE: current load completes, new one pends
    wr(A_VALID, 32'hb);
    wr(A_SEL, 32'd3);
    frame_end = 1'b1;
    exp_q.push_back(2'd3);
    seq_check(2'd3, 1'b1, "t5a");
    rd(A_STATUS, 32'h3, "t5_status_pending");
    rd(A_SEL, 32'd0, "t5_sel_readback");
    frame_end = 1'b1;
    exp_q.push_back(2'd0);
    seq_check(2'd0, 1'b0, "t5b");

    // Clear go while running: stop at frame_end, pending change discarded
    wr(A_SEL, 32'd1);
    wr(A_CTRL, 32'd0);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    chk("t4_running_drop", {31'd0, running}, 32'd0);
    chk("t4_no_load", {31'd0, mode_load}, 32'd0);
    rd(A_STATUS, 32'h0, "t4_status_discarded");
    wr(A_SEL, 32'd1);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_go0_no_load", {31'd0, mode_load}, 32'd0);
    end
    rd(A_STATUS, 32'h2, "t4_status_pending");

    // Reset during READ aborts the sequence with no load
    wr(A_CTRL, 32'd1);
    step();
    step();
    chk("t6_in_read", {31'd0, bank_rd}, 32'd1);
    chk("t6_read_addr", {30'd0, bank_addr}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("t6_rst_bank_rd", {31'd0, bank_rd}, 32'd0);
    chk("t6_rst_bank_addr", {30'd0, bank_addr}, 32'd0);
    chk("t6_rst_mode_load", {31'd0, mode_load}, 32'd0);
    chk("t6_rst_active", {30'd0, active_mode}, 32'd0);
    chk("t6_rst_running", {31'd0, running}, 32'd0);
    chk("t6_rst_readdata", av_readdata, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_no_load_after", {31'd0, mode_load}, 32'd0);
    end
    rd(A_CTRL, 32'd0, "t6_ctrl_cleared");

    step();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
